// File: rtl/vtx_tracer_if.sv
`default_nettype none
// ============================================================================
// Module   : vtx_tracer_if
// Brief    : Observed CPU/COP handshake, COP memory port and trace outputs.
// Revision : 1.0
// ============================================================================
interface vtx_tracer_if #(
   parameter int NMEM = 4,
   parameter int NCPR = 16
);
   logic                 cpu_insn_req;
   logic                 cpu_insn_ack;
   logic [31:0]          cpu_insn_enc;
   logic [31:0]          cpu_rs1;
   logic                 cop_insn_rsp;
   logic                 cop_insn_ack;
   logic [2:0]           cop_result;
   logic                 cop_wen;
   logic [4:0]           cop_waddr;
   logic [31:0]          cop_wdata;
   logic [32*NCPR-1:0]   cprs;
   logic                 mem_cen;
   logic                 mem_wen;
   logic                 mem_error;
   logic                 mem_gnt;
   logic [31:0]          mem_addr;
   logic [31:0]          mem_wdata;
   logic [31:0]          mem_rdata;
   logic [3:0]           mem_ben;
   logic [31:0]          rng_sample;

   logic                 vtx_reset;
   logic                 vtx_valid;
   logic [31:0]          vtx_instr_enc;
   logic [31:0]          vtx_instr_rs1;
   logic [31:0]          vtx_instr_wdata;
   logic [2:0]           vtx_instr_result;
   logic [4:0]           vtx_instr_waddr;
   logic                 vtx_instr_wen;
   logic [32*NCPR-1:0]   vtx_cprs_pre;
   logic [32*NCPR-1:0]   vtx_cprs_post;
   logic [NMEM-1:0]      vtx_mem_cen;
   logic [NMEM-1:0]      vtx_mem_wen;
   logic [NMEM-1:0]      vtx_mem_error;
   logic [32*NMEM-1:0]   vtx_mem_addr;
   logic [32*NMEM-1:0]   vtx_mem_wdata;
   logic [32*NMEM-1:0]   vtx_mem_rdata;
   logic [4*NMEM-1:0]    vtx_mem_ben;
   logic                 vtx_mem_ovf;
   logic                 vtx_proto_err;
   logic [31:0]          vtx_rand_sample;

   modport master (
      output cpu_insn_req, cpu_insn_ack, cpu_insn_enc, cpu_rs1,
             cop_insn_rsp, cop_insn_ack, cop_result, cop_wen, cop_waddr, cop_wdata,
             cprs, mem_cen, mem_wen, mem_error, mem_gnt, mem_addr, mem_wdata,
             mem_rdata, mem_ben, rng_sample,
      input  vtx_reset, vtx_valid, vtx_instr_enc, vtx_instr_rs1, vtx_instr_wdata,
             vtx_instr_result, vtx_instr_waddr, vtx_instr_wen, vtx_cprs_pre,
             vtx_cprs_post, vtx_mem_cen, vtx_mem_wen, vtx_mem_error, vtx_mem_addr,
             vtx_mem_wdata, vtx_mem_rdata, vtx_mem_ben, vtx_mem_ovf, vtx_proto_err,
             vtx_rand_sample
   );

   modport slave (
      input  cpu_insn_req, cpu_insn_ack, cpu_insn_enc, cpu_rs1,
             cop_insn_rsp, cop_insn_ack, cop_result, cop_wen, cop_waddr, cop_wdata,
             cprs, mem_cen, mem_wen, mem_error, mem_gnt, mem_addr, mem_wdata,
             mem_rdata, mem_ben, rng_sample,
      output vtx_reset, vtx_valid, vtx_instr_enc, vtx_instr_rs1, vtx_instr_wdata,
             vtx_instr_result, vtx_instr_waddr, vtx_instr_wen, vtx_cprs_pre,
             vtx_cprs_post, vtx_mem_cen, vtx_mem_wen, vtx_mem_error, vtx_mem_addr,
             vtx_mem_wdata, vtx_mem_rdata, vtx_mem_ben, vtx_mem_ovf, vtx_proto_err,
             vtx_rand_sample
   );
endinterface
`default_nettype wire

// File: rtl/vtx_tracer.sv
`default_nettype none
// ============================================================================
// Module   : vtx_tracer
// Brief    : Passive tracer emitting one record per retired COP instruction.
//            Define VTX_TRACER_RAND_EN to capture rng_sample with each record.
// Revision : 1.0
// ============================================================================
module vtx_tracer #(
   parameter int NMEM = 4,
   parameter int NCPR = 16
) (
   input  wire logic    g_clk,
   input  wire logic    g_resetn,
   vtx_tracer_if.slave  bus
);
   localparam int CW = $clog2(NMEM + 1);
   localparam int SW = $clog2(NMEM);
   localparam int PW = 32 * NCPR;
   localparam int MW = 32 * NMEM;
   localparam logic [CW-1:0] CNT_FULL = CW'(NMEM);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_POST = 2'd2
   } state_t;

   // Fields that a back-to-back request can overwrite while the old record is on show.
   typedef struct packed {
      logic [31:0]       enc;
      logic [31:0]       rs1;
      logic [PW-1:0]     pre;
      logic [NMEM-1:0]   cen;
      logic [NMEM-1:0]   wen;
      logic [NMEM-1:0]   err;
      logic [MW-1:0]     addr;
      logic [MW-1:0]     wdata;
      logic [MW-1:0]     rdata;
      logic [4*NMEM-1:0] ben;
      logic              ovf;
      logic [31:0]       rnd;
   } rec_t;

   state_t          state_q, state_d;
   rec_t            work_q, work_d;
   rec_t            snap_q, snap_d;
   rec_t            out_rec;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   slot;
   logic [2:0]      result_q, result_d;
   logic            iwen_q, iwen_d;
   logic [4:0]      waddr_q, waddr_d;
   logic [31:0]     iwdata_q, iwdata_d;
   logic [PW-1:0]   post_q, post_d;
   logic            valid_q, valid_d;
   logic            proto_err_q, proto_err_d;
   logic            reset_q, reset_d;
   logic [31:0]     rnd_in;
   logic            req_hs, rsp_hs, mem_hs;

   assign req_hs = bus.cpu_insn_req & bus.cpu_insn_ack;
   assign rsp_hs = bus.cop_insn_rsp & bus.cop_insn_ack;
   assign mem_hs = bus.mem_cen & bus.mem_gnt;
   assign slot   = cnt_q[SW-1:0];

`ifdef VTX_TRACER_RAND_EN
   assign rnd_in = bus.rng_sample;
`else
   logic unused_rng;
   assign rnd_in     = '0;
   assign unused_rng = ^bus.rng_sample;
`endif

   function automatic rec_t fresh_rec(input logic [31:0] enc, input logic [31:0] rs1,
                                      input logic [PW-1:0] pre, input logic [31:0] rnd);
      rec_t r;
      r     = '0;
      r.enc = enc;
      r.rs1 = rs1;
      r.pre = pre;
      r.rnd = rnd;
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      snap_d      = snap_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      iwen_d      = iwen_q;
      waddr_d     = waddr_q;
      iwdata_d    = iwdata_q;
      post_d      = post_q;
      valid_d     = 1'b0;
      proto_err_d = proto_err_q;
      reset_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rsp_hs) proto_err_d = 1'b1;
            if (req_hs) begin
               work_d  = fresh_rec(bus.cpu_insn_enc, bus.cpu_rs1, bus.cprs, rnd_in);
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (mem_hs) begin
               if (cnt_q == CNT_FULL) begin
                  work_d.ovf = 1'b1;
               end else begin
                  work_d.cen[slot]                 = 1'b1;
                  work_d.wen[slot]                 = bus.mem_wen;
                  work_d.err[slot]                 = bus.mem_error;
                  work_d.addr[{slot, 5'b0} +: 32]  = bus.mem_addr;
                  work_d.wdata[{slot, 5'b0} +: 32] = bus.mem_wdata;
                  work_d.rdata[{slot, 5'b0} +: 32] = bus.mem_rdata;
                  work_d.ben[{slot, 2'b0} +: 4]    = bus.mem_ben;
                  cnt_d                            = cnt_q + CW'(1);
               end
            end
            if (req_hs) proto_err_d = 1'b1;
            if (rsp_hs) begin
               result_d = bus.cop_result;
               iwen_d   = bus.cop_wen;
               waddr_d  = bus.cop_waddr;
               iwdata_d = bus.cop_wdata;
               state_d  = S_POST;
            end
         end
         S_POST: begin
            // CPR writes committed on the response edge are visible here.
            post_d  = bus.cprs;
            valid_d = ~reset_q;
            snap_d  = work_q;
            state_d = S_IDLE;
            if (rsp_hs) proto_err_d = 1'b1;
            if (req_hs) begin
               work_d  = fresh_rec(bus.cpu_insn_enc, bus.cpu_rs1, bus.cprs, rnd_in);
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q     <= S_IDLE;
         work_q      <= '0;
         snap_q      <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         iwen_q      <= 1'b0;
         waddr_q     <= '0;
         iwdata_q    <= '0;
         post_q      <= '0;
         valid_q     <= 1'b0;
         proto_err_q <= 1'b0;
         reset_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         snap_q      <= snap_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         iwen_q      <= iwen_d;
         waddr_q     <= waddr_d;
         iwdata_q    <= iwdata_d;
         post_q      <= post_d;
         valid_q     <= valid_d;
         proto_err_q <= proto_err_d;
         reset_q     <= reset_d;
      end
   end

   // During the pulse the frozen copy is shown; a new capture appears afterwards.
   assign out_rec = valid_q ? snap_q : work_q;

   assign bus.vtx_reset        = reset_q;
   assign bus.vtx_valid        = valid_q;
   assign bus.vtx_instr_enc    = out_rec.enc;
   assign bus.vtx_instr_rs1    = out_rec.rs1;
   assign bus.vtx_instr_wdata  = iwdata_q;
   assign bus.vtx_instr_result = result_q;
   assign bus.vtx_instr_waddr  = waddr_q;
   assign bus.vtx_instr_wen    = iwen_q;
   assign bus.vtx_cprs_pre     = out_rec.pre;
   assign bus.vtx_cprs_post    = post_q;
   assign bus.vtx_mem_cen      = out_rec.cen;
   assign bus.vtx_mem_wen      = out_rec.wen;
   assign bus.vtx_mem_error    = out_rec.err;
   assign bus.vtx_mem_addr     = out_rec.addr;
   assign bus.vtx_mem_wdata    = out_rec.wdata;
   assign bus.vtx_mem_rdata    = out_rec.rdata;
   assign bus.vtx_mem_ben      = out_rec.ben;
   assign bus.vtx_mem_ovf      = out_rec.ovf;
   assign bus.vtx_proto_err    = proto_err_q;
   assign bus.vtx_rand_sample  = out_rec.rnd;
endmodule
`default_nettype wire

// File: tb/tb_vtx_tracer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vtx_tracer
// Brief    : Self-checking bench for vtx_tracer (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_vtx_tracer;
   logic         clk = 1'b0;
   logic         rstn;
   logic [511:0] cprs_flat;
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;

   vtx_tracer_if #(.NMEM(4), .NCPR(16)) bus ();

   vtx_tracer #(.NMEM(4), .NCPR(16)) dut (
      .g_clk    (clk),
      .g_resetn (rstn),
      .bus      (bus)
   );

   assign bus.cprs = cprs_flat;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] enc, rs1, wdata, mbase, cpr3;
      logic [2:0]  result;
      logic        wen;
      logic [4:0]  waddr;
      int          nmem, gap;
      bit          stall, mem_with_rsp;
   } vec_t;

   typedef struct {
      logic [31:0]  enc, rs1, wdata, rnd;
      logic [2:0]   result;
      logic         wen;
      logic [4:0]   waddr;
      logic [3:0]   cen, mwen, merr;
      logic [127:0] maddr, mwdata, mrdata;
      logic [15:0]  mben;
      logic         ovf;
      logic [511:0] pre, post;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[5];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic mem_idle;
      bus.mem_cen = 1'b0; bus.mem_gnt = 1'b0; bus.mem_wen = 1'b0; bus.mem_error = 1'b0;
   endtask

   task automatic drive_mem(input vec_t v, input int k);
      bus.mem_cen   = 1'b1;
      bus.mem_gnt   = 1'b1;
      bus.mem_wen   = (k % 2 == 1);
      bus.mem_error = (k == 2);
      bus.mem_addr  = v.mbase + 32'(4 * k);
      bus.mem_wdata = 32'h21 + 32'(k);
      bus.mem_rdata = 32'h11 + 32'(k);
      bus.mem_ben   = (k == 3) ? 4'h6 : 4'hF;
   endtask

   task automatic run_insn(input vec_t v, input bit idle_after);
      exp_t e;
      e = '{default: '0};
      bus.cpu_insn_req = 1'b1; bus.cpu_insn_ack = 1'b1;
      bus.cpu_insn_enc = v.enc; bus.cpu_rs1 = v.rs1;
      bus.rng_sample   = $urandom;
      e.enc = v.enc; e.rs1 = v.rs1; e.pre = cprs_flat;
`ifdef VTX_TRACER_RAND_EN
      e.rnd = bus.rng_sample;
`endif
      tick;
      bus.cpu_insn_req = 1'b0; bus.cpu_insn_ack = 1'b0; bus.rng_sample = $urandom;
      for (int k = 0; k < v.nmem; k++) begin
         if (v.stall) begin
            bus.mem_cen = 1'b1; bus.mem_gnt = 1'b0; bus.mem_addr = 32'hBAD0_0000;
            tick;
         end
         drive_mem(v, k);
         if (k < 4) begin
            e.cen[k] = 1'b1; e.mwen[k] = bus.mem_wen; e.merr[k] = bus.mem_error;
            e.maddr[32*k +: 32]  = bus.mem_addr;
            e.mwdata[32*k +: 32] = bus.mem_wdata;
            e.mrdata[32*k +: 32] = bus.mem_rdata;
            e.mben[4*k +: 4]     = bus.mem_ben;
         end
         if (k == v.nmem - 1 && v.mem_with_rsp) break;
         tick;
         mem_idle;
      end
      if (!(v.mem_with_rsp && v.nmem > 0)) repeat (v.gap) tick;
      bus.cop_insn_rsp = 1'b1; bus.cop_insn_ack = 1'b1;
      bus.cop_result = v.result; bus.cop_wen = v.wen;
      bus.cop_waddr = v.waddr; bus.cop_wdata = v.wdata;
      tick;
      bus.cop_insn_rsp = 1'b0; bus.cop_insn_ack = 1'b0;
      mem_idle;
      // The COP commits its CPR write on the response edge.
      cprs_flat[96 +: 32] = v.cpr3;
      e.result = v.result; e.wen = v.wen; e.waddr = v.waddr; e.wdata = v.wdata;
      e.ovf  = (v.nmem > 4);
      e.post = cprs_flat;
      e.cyc  = cyc + 1;
      sb.push_back(e);
      if (idle_after) repeat (3) tick;
   endtask

   always @(posedge clk) begin
      #1;
      if (bus.vtx_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid=1 at cycle %0d expected no record", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("latency", cyc, e.cyc);
            chk("enc", bus.vtx_instr_enc, e.enc);
            chk("rs1", bus.vtx_instr_rs1, e.rs1);
            chk("result", bus.vtx_instr_result, e.result);
            chk("wen", bus.vtx_instr_wen, e.wen);
            chk("waddr", bus.vtx_instr_waddr, e.waddr);
            chk("wdata", bus.vtx_instr_wdata, e.wdata);
            chk("mem_cen", bus.vtx_mem_cen, e.cen);
            chk("mem_wen", bus.vtx_mem_wen & e.cen, e.mwen);
            chk("mem_err", bus.vtx_mem_error & e.cen, e.merr);
            for (int k = 0; k < 4; k++) begin
               if (e.cen[k]) begin
                  chk("mem_addr", bus.vtx_mem_addr[32*k +: 32], e.maddr[32*k +: 32]);
                  chk("mem_wdata", bus.vtx_mem_wdata[32*k +: 32], e.mwdata[32*k +: 32]);
                  chk("mem_rdata", bus.vtx_mem_rdata[32*k +: 32], e.mrdata[32*k +: 32]);
                  chk("mem_ben", bus.vtx_mem_ben[4*k +: 4], e.mben[4*k +: 4]);
               end
            end
            chk("mem_ovf", bus.vtx_mem_ovf, e.ovf);
            chk("cprs_pre", bus.vtx_cprs_pre, e.pre);
            chk("cprs_post", bus.vtx_cprs_post, e.post);
            chk("rand", bus.vtx_rand_sample, e.rnd);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{enc: 32'h0000_1234, rs1: 32'd5, wdata: 32'hAA, mbase: 32'h0, cpr3: 32'h0,
                  result: 3'd0, wen: 1'b1, waddr: 5'd7, nmem: 0, gap: 2, stall: 1'b0, mem_with_rsp: 1'b0};
      vecs[1] = '{enc: 32'h0000_2003, rs1: 32'h100, wdata: 32'h0, mbase: 32'h100, cpr3: 32'h0,
                  result: 3'd1, wen: 1'b0, waddr: 5'd0, nmem: 2, gap: 1, stall: 1'b1, mem_with_rsp: 1'b0};
      vecs[2] = '{enc: 32'h8000_0007, rs1: 32'hCAFE_0000, wdata: 32'hFFFF_FFFF, mbase: 32'h2000, cpr3: 32'h0,
                  result: 3'd2, wen: 1'b1, waddr: 5'd31, nmem: 5, gap: 0, stall: 1'b0, mem_with_rsp: 1'b0};
      vecs[3] = '{enc: 32'h0000_3303, rs1: 32'h3, wdata: 32'h5555_AAAA, mbase: 32'h300, cpr3: 32'hDEAD_BEEF,
                  result: 3'd7, wen: 1'b1, waddr: 5'd1, nmem: 4, gap: 0, stall: 1'b1, mem_with_rsp: 1'b0};
      vecs[4] = '{enc: 32'h4000_0044, rs1: 32'hFFFF_FFFF, wdata: 32'h0102_0304, mbase: 32'h400, cpr3: 32'h1234_5678,
                  result: 3'd3, wen: 1'b0, waddr: 5'd12, nmem: 3, gap: 0, stall: 1'b0, mem_with_rsp: 1'b1};

      for (int i = 0; i < 16; i++) cprs_flat[32*i +: 32] = (i == 3) ? 32'h0 : 32'h1111_1111 * 32'(i);
      bus.cpu_insn_req = 1'b0; bus.cpu_insn_ack = 1'b0; bus.cpu_insn_enc = '0; bus.cpu_rs1 = '0;
      bus.cop_insn_rsp = 1'b0; bus.cop_insn_ack = 1'b0; bus.cop_result = '0; bus.cop_wen = 1'b0;
      bus.cop_waddr = '0; bus.cop_wdata = '0; bus.mem_addr = '0; bus.mem_wdata = '0;
      bus.mem_rdata = '0; bus.mem_ben = '0; bus.rng_sample = '0;
      mem_idle;
      rstn = 1'b0;
      repeat (3) tick;

      chk("rst_vtx_reset", bus.vtx_reset, 1'b1);
      chk("rst_valid", bus.vtx_valid, 1'b0);
      chk("rst_enc", bus.vtx_instr_enc, 32'h0);
      chk("rst_pre", bus.vtx_cprs_pre, 512'h0);
      chk("rst_cen", bus.vtx_mem_cen, 4'h0);
      chk("rst_proto", bus.vtx_proto_err, 1'b0);
      chk("rst_rand", bus.vtx_rand_sample, 32'h0);
      rstn = 1'b1;
      chk("rel_reset_hold", bus.vtx_reset, 1'b1);
      tick;
      chk("rel_reset_drop", bus.vtx_reset, 1'b0);

      for (int i = 0; i < 5; i++) run_insn(vecs[i], 1'b1);

      // Back-to-back: the second request lands on the first one's POST edge.
      run_insn(vecs[4], 1'b0);
      run_insn(vecs[1], 1'b1);
      chk("b2b_no_proto", bus.vtx_proto_err, 1'b0);
      chk("hold_enc", bus.vtx_instr_enc, vecs[1].enc);
      chk("hold_valid_low", bus.vtx_valid, 1'b0);

      bus.cop_insn_rsp = 1'b1; bus.cop_insn_ack = 1'b1;
      tick;
      bus.cop_insn_rsp = 1'b0; bus.cop_insn_ack = 1'b0;
      chk("idle_rsp_proto", bus.vtx_proto_err, 1'b1);
      repeat (4) tick;
      chk("idle_rsp_sticky", bus.vtx_proto_err, 1'b1);

      bus.cpu_insn_req = 1'b1; bus.cpu_insn_ack = 1'b1; bus.cpu_insn_enc = 32'hDEAD_0001;
      tick;
      bus.cpu_insn_req = 1'b0; bus.cpu_insn_ack = 1'b0;
      drive_mem(vecs[1], 0);
      tick;
      mem_idle;
      #2 rstn = 1'b0;
      #1;
      chk("midrst_reset", bus.vtx_reset, 1'b1);
      chk("midrst_proto", bus.vtx_proto_err, 1'b0);
      chk("midrst_enc", bus.vtx_instr_enc, 32'h0);
      chk("midrst_cen", bus.vtx_mem_cen, 4'h0);
      repeat (2) tick;
      rstn = 1'b1;
      tick;
      chk("midrst_reset_drop", bus.vtx_reset, 1'b0);
      run_insn(vecs[0], 1'b1);

      repeat (4) tick;
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
